// File: rtl/des_pkg.sv
// Shared DES key-schedule constants.
// Holds the PC-1 and PC-2 tables as 1-based DES bit indices, where DES bit 1
// is the MSB of the vector. It also holds the per-round left-shift amounts
// and the datapath widths used by des_key_schedule and des_pc2.
package des_pkg;

    localparam int unsigned KEY_W    = 64;
    localparam int unsigned CD_W     = 28;
    localparam int unsigned SUBKEY_W = 48;
    localparam int unsigned ROUND_W  = 4;
    localparam int unsigned ROUNDS   = 16;

    // PC-1: entry i selects DES key bit PC1_TABLE[i] for output bit i+1 of {C,D}.
    localparam int unsigned PC1_TABLE [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // PC-2: entry i selects {C,D} bit PC2_TABLE[i] for subkey bit i+1.
    localparam int unsigned PC2_TABLE [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Left rotation applied before round 1..16 (index 0 = round 1).
    localparam logic [1:0] SHIFT_TABLE [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } ks_state_t;

endpackage

// File: rtl/des_pc2.sv
// DES Permuted Choice 2: a purely combinational 56-to-48 bit selection.
// Ports:
//   cd     - in  56: concatenated {C,D}, bit 55 = DES bit 1
//   subkey - out 48: round subkey, bit 47 = PC-2 output bit 1
module des_pc2
    import des_pkg::*;
(
    input  logic [2*CD_W-1:0]   cd,
    output logic [SUBKEY_W-1:0] subkey
);

    for (genvar i = 0; i < SUBKEY_W; i++) begin : g_sel
        assign subkey[SUBKEY_W-1-i] = cd[2*CD_W - PC2_TABLE[i]];
    end

    // PC-2 drops DES bits 9, 18, 22, 25, 35, 38, 43 and 54 of {C,D}.
    logic unused_cd;
    assign unused_cd = ^{cd[47], cd[38], cd[34], cd[31],
                         cd[21], cd[18], cd[13], cd[2]};

endmodule

// File: rtl/des_key_schedule.sv
// DES key schedule: produces the 16 round subkeys, one at a time.
// The subkeys come out in encrypt order (K1..K16) or decrypt order (K16..K1).
// Ports:
//   clk, rst_n    - clock (rising edge), asynchronous active-low reset
//   key_load      - strobe: capture key_in/decrypt and start a schedule
//   key_in        - 64-bit DES key, bit 63 = DES bit 1, parity bits ignored
//   decrypt       - order select sampled with key_load (1 = K16..K1)
//   next          - advance to the following subkey while subkey_valid
//   subkey        - current 48-bit round subkey
//   round_cnt     - current round index 0..15
//   subkey_valid  - subkey/round_cnt are meaningful
//   done          - one-cycle pulse after the 16th subkey is consumed
module des_key_schedule
    import des_pkg::*;
#(
    parameter int unsigned START_ROUND = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_load,
    input  logic [KEY_W-1:0]    key_in,
    input  logic                decrypt,
    input  logic                next,
    output logic [SUBKEY_W-1:0] subkey,
    output logic [ROUND_W-1:0]  round_cnt,
    output logic                subkey_valid,
    output logic                done
);

    localparam logic [ROUND_W-1:0] ROUND_FIRST = ROUND_W'(START_ROUND);
    localparam logic [ROUND_W-1:0] ROUND_LAST  = ROUND_W'(START_ROUND + ROUNDS - 1);

    ks_state_t state, state_nxt;

    logic [CD_W-1:0]    c_q, d_q;
    logic [CD_W-1:0]    c_load, d_load;
    logic [CD_W-1:0]    c_step, d_step;
    logic [2*CD_W-1:0]  cd_pc1;
    logic [ROUND_W-1:0] round_q;
    logic [ROUND_W-1:0] round_rel;
    logic [ROUND_W-1:0] idx_enc, idx_dec;
    logic [1:0]         shift_amt;
    logic               mode_q;
    logic               done_q;
    logic               advance;
    logic               finish;

    // PC-1 straight from the key input.
    for (genvar i = 0; i < 2*CD_W; i++) begin : g_pc1
        assign cd_pc1[2*CD_W-1-i] = key_in[KEY_W - PC1_TABLE[i]];
    end

    // Parity bits (DES bits 8, 16, ..., 64) do not enter the schedule.
    logic unused_parity;
    assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                             key_in[24], key_in[16], key_in[8],  key_in[0]};

    // Encrypt preloads the round-1 rotation so K1 appears right after the load.
    // Decrypt loads C0D0 unrotated: the 16 shifts total 28, so C0D0 = C16D16.
    always_comb begin
        c_load = cd_pc1[2*CD_W-1:CD_W];
        d_load = cd_pc1[CD_W-1:0];
        if (!decrypt) begin
            c_load = {c_load[CD_W-2:0], c_load[CD_W-1]};
            d_load = {d_load[CD_W-2:0], d_load[CD_W-1]};
        end
    end

    // Round r -> r+1 uses SHIFT[r+2] left (encrypt) or SHIFT[16-r] right
    // (decrypt). The indices are 0-based here and wrap harmlessly at r = 15,
    // where the step is never taken.
    always_comb begin
        round_rel = round_q - ROUND_FIRST;
        idx_enc   = round_rel + 4'd1;
        idx_dec   = 4'd15 - round_rel;
        shift_amt = mode_q ? SHIFT_TABLE[idx_dec] : SHIFT_TABLE[idx_enc];
        if (mode_q) begin
            if (shift_amt == 2'd2) begin
                c_step = {c_q[1:0], c_q[CD_W-1:2]};
                d_step = {d_q[1:0], d_q[CD_W-1:2]};
            end else begin
                c_step = {c_q[0], c_q[CD_W-1:1]};
                d_step = {d_q[0], d_q[CD_W-1:1]};
            end
        end else begin
            if (shift_amt == 2'd2) begin
                c_step = {c_q[CD_W-3:0], c_q[CD_W-1:CD_W-2]};
                d_step = {d_q[CD_W-3:0], d_q[CD_W-1:CD_W-2]};
            end else begin
                c_step = {c_q[CD_W-2:0], c_q[CD_W-1]};
                d_step = {d_q[CD_W-2:0], d_q[CD_W-1]};
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a load always wins over next.
    always_comb begin
        advance   = (state == ST_ACTIVE) && next && !key_load;
        finish    = advance && (round_q == ROUND_LAST);
        state_nxt = state;
        if (key_load) begin
            state_nxt = ST_ACTIVE;
        end else if (finish) begin
            state_nxt = ST_IDLE;
        end
    end

    // Key halves, round index, mode and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= finish;
            if (key_load) begin
                c_q     <= c_load;
                d_q     <= d_load;
                round_q <= ROUND_FIRST;
                mode_q  <= decrypt;
            end else if (advance && !finish) begin
                c_q     <= c_step;
                d_q     <= d_step;
                round_q <= round_q + 4'd1;
            end
        end
    end

    des_pc2 u_pc2 (
        .cd     ({c_q, d_q}),
        .subkey (subkey)
    );

    // Outputs.
    always_comb begin
        subkey_valid = (state == ST_ACTIVE);
        round_cnt    = round_q;
        done         = done_q;
    end

endmodule

// File: tb/tb_des_key_schedule.sv
module tb_des_key_schedule;

    logic        clk;
    logic        rst_n;
    logic        key_load;
    logic [63:0] key_in;
    logic        decrypt;
    logic        next;
    logic [47:0] subkey;
    logic [3:0]  round_cnt;
    logic        subkey_valid;
    logic        done;

    int n_cmp  = 0;
    int n_fail = 0;

    des_key_schedule #(.START_ROUND(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_load     (key_load),
        .key_in       (key_in),
        .decrypt      (decrypt),
        .next         (next),
        .subkey       (subkey),
        .round_cnt    (round_cnt),
        .subkey_valid (subkey_valid),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (textbook DES key schedule) ----------
    localparam int PC1_T [56] = '{
        57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
        19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
        14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{
        14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
        41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int SH_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    logic [47:0] ref_ks [16];
    logic        ref_dec;

    // Fills ref_ks[0..15] with K1..K16 by rotating one bit at a time.
    task automatic build_ref(input logic [63:0] key);
        logic [55:0] cd;
        logic [27:0] c, d;
        for (int i = 0; i < 56; i++) cd[6'(55 - i)] = key[6'(64 - PC1_T[i])];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < SH_T[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int j = 0; j < 48; j++) ref_ks[4'(r)][6'(47 - j)] = cd[6'(56 - PC2_T[j])];
        end
    endtask

    function automatic logic [47:0] exp_key(input int k);
        return ref_dec ? ref_ks[4'(15 - k)] : ref_ks[4'(k)];
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [63:0] key, input logic dec, input logic nx);
        key_in   = key;
        decrypt  = dec;
        next     = nx;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
    endtask

    // Full schedule with next asserted at the given duty (percent).
    task automatic run_sched(input logic [63:0] key, input logic dec, input int duty);
        int k;
        int cyc;
        bit fin;
        build_ref(key);
        ref_dec = dec;
        load(key, dec, 1'b0);
        cyc = 1;
        k   = 0;
        fin = 1'b0;
        while (!fin && cyc < 400) begin
            check("valid", 64'(subkey_valid), 64'd1);
            check("round", 64'(round_cnt), 64'(k));
            check("subkey", 64'(subkey), 64'(exp_key(k)));
            check("done_low", 64'(done), 64'd0);
            next = ($urandom_range(0, 99) < duty);
            tick();
            cyc++;
            if (next) begin
                if (k == 15) fin = 1'b1;
                else k++;
            end
        end
        next = 1'b0;
        check("finished", 64'(fin), 64'd1);
        if (fin) begin
            check("done_pulse", 64'(done), 64'd1);
            check("valid_drop", 64'(subkey_valid), 64'd0);
            check("round_hold", 64'(round_cnt), 64'd15);
            if (duty >= 100) check("latency", 64'(cyc), 64'd17);
            tick();
            check("done_once", 64'(done), 64'd0);
            check("idle_valid", 64'(subkey_valid), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;

    initial begin
        logic [63:0] kb;
        rst_n    = 1'b0;
        key_load = 1'b0;
        key_in   = '0;
        decrypt  = 1'b0;
        next     = 1'b0;
        #3;
        check("rst_valid", 64'(subkey_valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_round", 64'(round_cnt), 64'd0);
        check("rst_subkey", 64'(subkey), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Known-answer vector, encrypt order.
        load(KEY_A, 1'b0, 1'b0);
        check("kat_k1", 64'(subkey), 64'h1B02EFFC7072);
        check("kat_k1_round", 64'(round_cnt), 64'd0);
        next = 1'b1;
        tick();
        check("kat_k2", 64'(subkey), 64'h79AED9DBC9E5);
        check("kat_k2_round", 64'(round_cnt), 64'd1);
        repeat (14) tick();
        check("kat_k16", 64'(subkey), 64'hCB3D8B0E17F5);
        check("kat_k16_round", 64'(round_cnt), 64'd15);
        tick();
        check("kat_done", 64'(done), 64'd1);
        check("kat_valid_drop", 64'(subkey_valid), 64'd0);
        next = 1'b0;
        tick();

        // Known-answer vector, decrypt order.
        load(KEY_A, 1'b1, 1'b0);
        check("kat_dec_first", 64'(subkey), 64'hCB3D8B0E17F5);
        next = 1'b1;
        repeat (15) tick();
        check("kat_dec_last", 64'(subkey), 64'h1B02EFFC7072);
        next = 1'b0;

        run_sched(KEY_A, 1'b0, 100);
        run_sched(KEY_A, 1'b1, 100);
        run_sched(KEY_A, 1'b0, 40);
        run_sched(KEY_A, 1'b1, 40);
        run_sched(64'h0, 1'b0, 100);
        run_sched(64'h0, 1'b1, 100);
        run_sched('1, 1'b0, 100);
        run_sched('1, 1'b1, 100);
        check("zero_key_model", 64'(ref_ks[7]), 64'hFFFFFFFFFFFF);

        for (int n = 0; n < 6; n++) begin
            kb = {$urandom, $urandom};
            run_sched(kb, 1'($urandom_range(0, 1)), int'($urandom_range(30, 100)));
        end

        // Restart mid-schedule with next also asserted: load wins, no done.
        load(KEY_A, 1'b0, 1'b1);
        repeat (7) tick();
        check("restart_at7", 64'(round_cnt), 64'd7);
        kb = {$urandom, $urandom};
        build_ref(kb);
        ref_dec = 1'b0;
        load(kb, 1'b0, 1'b1);
        check("restart_round", 64'(round_cnt), 64'd0);
        check("restart_subkey", 64'(subkey), 64'(exp_key(0)));
        check("restart_valid", 64'(subkey_valid), 64'd1);
        check("restart_nodone", 64'(done), 64'd0);
        for (int k = 1; k < 16; k++) begin
            tick();
            check("restart_seq", 64'(subkey), 64'(exp_key(k)));
            check("restart_seq_done", 64'(done), 64'd0);
        end
        tick();
        check("restart_done", 64'(done), 64'd1);
        next = 1'b0;
        tick();

        // Load coinciding with the final next: load wins, no done pulse.
        build_ref(KEY_A);
        ref_dec = 1'b1;
        load(KEY_A, 1'b0, 1'b1);
        repeat (15) tick();
        check("ld_done_round15", 64'(round_cnt), 64'd15);
        load(KEY_A, 1'b1, 1'b1);
        check("ld_done_nodone", 64'(done), 64'd0);
        check("ld_done_valid", 64'(subkey_valid), 64'd1);
        check("ld_done_round", 64'(round_cnt), 64'd0);
        check("ld_done_subkey", 64'(subkey), 64'(exp_key(0)));
        next = 1'b0;

        // Asynchronous reset mid-clock at round 5.
        load(KEY_A, 1'b0, 1'b1);
        repeat (5) tick();
        check("arst_pre_round", 64'(round_cnt), 64'd5);
        next = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(subkey_valid), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_round", 64'(round_cnt), 64'd0);
        check("arst_subkey", 64'(subkey), 64'd0);
        #2;
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            next = 1'b1;
            tick();
            check("post_rst_valid", 64'(subkey_valid), 64'd0);
            check("post_rst_round", 64'(round_cnt), 64'd0);
            check("post_rst_done", 64'(done), 64'd0);
            check("post_rst_subkey", 64'(subkey), 64'd0);
        end
        next = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
